// File: rtl/cp0_regfile_if.sv
// MFC0/MTC0 access bus between the pipeline (master) and the CP0 register file (slave).
interface cp0_regfile_if;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [4:0]  raddr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport master (output we_i, waddr_i, raddr_i, data_i, input data_o);
  modport slave  (input we_i, waddr_i, raddr_i, data_i, output data_o);
endinterface

// File: rtl/cp0_regfile.sv
// CP0 register file (BadVAddr/Count/Compare/Status/Cause/EPC); commits exceptions/ERET and serves MFC0/MTC0.
// Latency: state updates 1 cycle after inputs, MFC0 read is combinational; no backpressure, accepts every cycle.
// Optional timer interrupt on Count==Compare is built when CP0_TIMER_INT_EN is defined.
module cp0_regfile #(
  parameter logic [31:0] RESET_STATUS = 32'h0040_0000,
  parameter int          COUNT_DIV    = 2
) (
  input  logic               clk,
  input  logic               rst,
  cp0_regfile_if.slave       bus,
  input  logic [5:0]         int_i,
  input  logic [31:0]        except_type_i,
  input  logic [31:0]        current_inst_addr_i,
  input  logic               is_in_delayslot_i,
  input  logic [31:0]        bad_addr_i,
  output logic [31:0]        status_o,
  output logic [31:0]        cause_o,
  output logic [31:0]        epc_o,
  output logic [31:0]        count_o,
  output logic [31:0]        compare_o,
  output logic [31:0]        badvaddr_o,
  output logic               timer_int_o
);

  localparam logic [4:0]  REG_BADVADDR = 5'd8;
  localparam logic [4:0]  REG_COUNT    = 5'd9;
  localparam logic [4:0]  REG_COMPARE  = 5'd11;
  localparam logic [4:0]  REG_STATUS   = 5'd12;
  localparam logic [4:0]  REG_CAUSE    = 5'd13;
  localparam logic [4:0]  REG_EPC      = 5'd14;

  localparam logic [31:0] EXC_NONE = 32'h0;
  localparam logic [31:0] EXC_INT  = 32'h1;
  localparam logic [31:0] EXC_ADEL = 32'h4;
  localparam logic [31:0] EXC_ADES = 32'h5;
  localparam logic [31:0] EXC_ERET = 32'hE;

  // Status bits software may change: IM[15:8], EXL, IE
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

  localparam int DW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(COUNT_DIV - 1);

  logic [DW-1:0] div_q;
  logic          exc_take;
  logic          eret;
  logic          mtc0;
  logic [4:0]    exc_code;

  assign exc_take = (except_type_i != EXC_NONE) && (except_type_i != EXC_ERET);
  assign eret     = (except_type_i == EXC_ERET);
  // A flushed instruction's MTC0 must not land
  assign mtc0     = bus.we_i && !exc_take && !eret;
  assign exc_code = (except_type_i == EXC_INT) ? 5'd0 : except_type_i[4:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      status_o   <= RESET_STATUS;
      cause_o    <= '0;
      epc_o      <= '0;
      count_o    <= '0;
      compare_o  <= '0;
      badvaddr_o <= '0;
      div_q      <= '0;
    end else begin
      if (mtc0 && bus.waddr_i == REG_COUNT) begin
        count_o <= bus.data_i;
        div_q   <= '0;
      end else if (div_q == DIV_LAST) begin
        div_q   <= '0;
        count_o <= count_o + 32'd1;
      end else begin
        div_q   <= div_q + 1'b1;
      end

      if (mtc0 && bus.waddr_i == REG_COMPARE) compare_o <= bus.data_i;
      if (mtc0 && bus.waddr_i == REG_EPC)     epc_o     <= bus.data_i;
      if (mtc0 && bus.waddr_i == REG_STATUS)
        status_o <= (status_o & ~STATUS_WMASK) | (bus.data_i & STATUS_WMASK);
      if (mtc0 && bus.waddr_i == REG_CAUSE)   cause_o[9:8] <= bus.data_i[9:8];

      cause_o[15:10] <= {int_i[5] | timer_int_o, int_i[4:0]};

      if (exc_take) begin
        // Nested exception keeps the original return address and BD
        if (!status_o[1]) begin
          epc_o      <= is_in_delayslot_i ? current_inst_addr_i - 32'd4 : current_inst_addr_i;
          cause_o[31] <= is_in_delayslot_i;
        end
        status_o[1]  <= 1'b1;
        cause_o[6:2] <= exc_code;
        if (except_type_i == EXC_ADEL || except_type_i == EXC_ADES) badvaddr_o <= bad_addr_i;
      end else if (eret) begin
        status_o[1] <= 1'b0;
      end
    end
  end

`ifdef CP0_TIMER_INT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_int_o <= 1'b0;
    end else if (mtc0 && bus.waddr_i == REG_COMPARE) begin
      timer_int_o <= 1'b0;
    end else if (compare_o != 32'd0 && count_o == compare_o) begin
      timer_int_o <= 1'b1;
    end
  end
`else
  assign timer_int_o = 1'b0;
`endif

  always_comb begin
    bus.data_o = 32'd0;
    case (bus.raddr_i)
      REG_BADVADDR: bus.data_o = badvaddr_o;
      REG_COUNT:    bus.data_o = count_o;
      REG_COMPARE:  bus.data_o = compare_o;
      REG_STATUS:   bus.data_o = status_o;
      REG_CAUSE:    bus.data_o = cause_o;
      REG_EPC:      bus.data_o = epc_o;
      default:      bus.data_o = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_regfile.sv
// Bench for cp0_regfile: reset checks, a vector table of one-cycle operations, and timer/interrupt sequences.
module tb_cp0_regfile;

  typedef enum logic [3:0] {
    C_STATUS, C_CAUSE, C_EPC, C_COUNT, C_COMPARE, C_BADV, C_TIMER, C_DATA, C_CAUSE15
  } sel_e;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] exc;
    logic [31:0] pc;
    logic        ds;
    logic [31:0] bad;
    logic [5:0]  intr;
    logic [4:0]  raddr;
    sel_e        sel;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    sel_e        sel;
    logic [31:0] exp;
    int          idx;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  int_i = '0;
  logic [31:0] except_type_i = '0;
  logic [31:0] current_inst_addr_i = '0;
  logic        is_in_delayslot_i = 1'b0;
  logic [31:0] bad_addr_i = '0;
  logic [31:0] status_o, cause_o, epc_o, count_o, compare_o, badvaddr_o;
  logic        timer_int_o;

  cp0_regfile_if bus ();

  cp0_regfile dut (
    .clk                 (clk),
    .rst                 (rst),
    .bus                 (bus.slave),
    .int_i               (int_i),
    .except_type_i       (except_type_i),
    .current_inst_addr_i (current_inst_addr_i),
    .is_in_delayslot_i   (is_in_delayslot_i),
    .bad_addr_i          (bad_addr_i),
    .status_o            (status_o),
    .cause_o             (cause_o),
    .epc_o               (epc_o),
    .count_o             (count_o),
    .compare_o           (compare_o),
    .badvaddr_o          (badvaddr_o),
    .timer_int_o         (timer_int_o)
  );

  always #5 clk = ~clk;

  vec_t vecs[$];
  sb_t  sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic string sel_name(sel_e s);
    case (s)
      C_STATUS:  return "status";
      C_CAUSE:   return "cause";
      C_EPC:     return "epc";
      C_COUNT:   return "count";
      C_COMPARE: return "compare";
      C_BADV:    return "badvaddr";
      C_TIMER:   return "timer_int";
      C_DATA:    return "data_o";
      default:   return "cause15";
    endcase
  endfunction

  function automatic logic [31:0] actual(sel_e s);
    case (s)
      C_STATUS:  return status_o;
      C_CAUSE:   return cause_o;
      C_EPC:     return epc_o;
      C_COUNT:   return count_o;
      C_COMPARE: return compare_o;
      C_BADV:    return badvaddr_o;
      C_TIMER:   return {31'd0, timer_int_o};
      C_DATA:    return bus.data_o;
      default:   return {31'd0, cause_o[15]};
    endcase
  endfunction

  task automatic add(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                     input logic [31:0] exc, input logic [31:0] pc, input logic ds,
                     input logic [31:0] bad, input logic [5:0] intr, input logic [4:0] raddr,
                     input sel_e sel, input logic [31:0] exp);
    vec_t v;
    v.we = we; v.waddr = waddr; v.wdata = wdata; v.exc = exc; v.pc = pc; v.ds = ds;
    v.bad = bad; v.intr = intr; v.raddr = raddr; v.sel = sel; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    bus.we_i = v.we; bus.waddr_i = v.waddr; bus.data_i = v.wdata; bus.raddr_i = v.raddr;
    except_type_i = v.exc; current_inst_addr_i = v.pc; is_in_delayslot_i = v.ds;
    bad_addr_i = v.bad; int_i = v.intr;
  endtask

  task automatic expect_now(input sel_e sel, input logic [31:0] exp, input int idx);
    sb_t e;
    e.sel = sel; e.exp = exp; e.idx = idx;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    sb_t e;
    logic [31:0] a;
    e = sb.pop_front();
    a = actual(e.sel);
    n_vec++;
    if (a !== e.exp) begin
      n_fail++;
      $display("FAIL vec%0d %s: got %h want %h", e.idx, sel_name(e.sel), a, e.exp);
    end
  endtask

  // One-cycle operation: drive, clock, then compare the post-edge value
  task automatic step(input vec_t v, input int idx);
    drive(v);
    expect_now(v.sel, v.exp, idx);
    @(posedge clk); #1;
    check_pop();
  endtask

  task automatic idle_cycle();
    vec_t v;
    v = '{we:1'b0, waddr:5'd0, wdata:32'd0, exc:32'd0, pc:32'd0, ds:1'b0, bad:32'd0,
          intr:6'd0, raddr:5'd0, sel:C_STATUS, exp:32'd0};
    drive(v);
    @(posedge clk); #1;
  endtask

  function automatic vec_t mk(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                              input sel_e sel, input logic [31:0] exp);
    vec_t v;
    v = '{we:we, waddr:waddr, wdata:wdata, exc:32'd0, pc:32'd0, ds:1'b0, bad:32'd0,
          intr:6'd0, raddr:5'd0, sel:sel, exp:exp};
    return v;
  endfunction

  initial begin
    bus.we_i = 1'b0; bus.waddr_i = '0; bus.raddr_i = '0; bus.data_i = '0;

    //   we  wa    wdata          exc    pc            ds bad           int      ra    sel        exp
    add(0, 5'd0,  32'h0,         32'h0, 32'h0,        0, 32'h0,        6'h00,  5'd0,  C_COUNT,   32'd0);
    add(0, 5'd0,  32'h0,         32'h0, 32'h0,        0, 32'h0,        6'h00,  5'd0,  C_COUNT,   32'd1);
    add(0, 5'd0,  32'h0,         32'h0, 32'h0,        0, 32'h0,        6'h00,  5'd0,  C_COUNT,   32'd1);
    add(0, 5'd0,  32'h0,         32'h0, 32'h0,        0, 32'h0,        6'h00,  5'd0,  C_COUNT,   32'd2);
    add(0, 5'd0,  32'h0,         32'h0, 32'h0,        0, 32'h0,        6'h00,  5'd0,  C_COUNT,   32'd2);
    add(0, 5'd0,  32'h0,         32'h0, 32'h0,        0, 32'h0,        6'h00,  5'd9,  C_DATA,    32'd3);
    add(1, 5'd12, 32'hFFFF_FFFF, 32'h0, 32'h0,        0, 32'h0,        6'h00,  5'd0,  C_STATUS,  32'h0040_FF03);
    add(1, 5'd12, 32'h0,         32'h0, 32'h0,        0, 32'h0,        6'h00,  5'd0,  C_STATUS,  32'h0040_0000);
    add(1, 5'd8,  32'h1234,      32'h0, 32'h0,        0, 32'h0,        6'h00,  5'd0,  C_BADV,    32'h0);
    add(1, 5'd3,  32'hDEAD_BEEF, 32'h0, 32'h0,        0, 32'h0,        6'h00,  5'd3,  C_DATA,    32'h0);
    add(0, 5'd0,  32'h0,         32'h4, 32'hBFC0_0100, 1, 32'h8000_0003, 6'h00, 5'd0,  C_EPC,     32'hBFC0_00FC);
    add(0, 5'd0,  32'h0,         32'h0, 32'h0,        0, 32'h0,        6'h00,  5'd0,  C_CAUSE,   32'h8000_0010);
    add(0, 5'd0,  32'h0,         32'h0, 32'h0,        0, 32'h0,        6'h00,  5'd0,  C_BADV,    32'h8000_0003);
    add(0, 5'd0,  32'h0,         32'h0, 32'h0,        0, 32'h0,        6'h00,  5'd0,  C_STATUS,  32'h0040_0002);
    add(0, 5'd0,  32'h0,         32'h8, 32'h200,      0, 32'h0,        6'h00,  5'd0,  C_EPC,     32'hBFC0_00FC);
    add(0, 5'd0,  32'h0,         32'h0, 32'h0,        0, 32'h0,        6'h00,  5'd0,  C_CAUSE,   32'h8000_0020);
    add(1, 5'd14, 32'h5,         32'hE, 32'h0,        0, 32'h0,        6'h00,  5'd0,  C_STATUS,  32'h0040_0000);
    add(0, 5'd0,  32'h0,         32'h0, 32'h0,        0, 32'h0,        6'h00,  5'd14, C_DATA,    32'hBFC0_00FC);
    add(1, 5'd14, 32'h1234_5678, 32'h0, 32'h0,        0, 32'h0,        6'h00,  5'd0,  C_EPC,     32'h1234_5678);
    add(1, 5'd13, 32'hFFFF_FFFF, 32'h0, 32'h0,        0, 32'h0,        6'h00,  5'd0,  C_CAUSE,   32'h8000_0320);
    add(0, 5'd0,  32'h0,         32'h0, 32'h0,        0, 32'h0,        6'h04,  5'd0,  C_CAUSE,   32'h8000_1320);
    add(0, 5'd0,  32'h0,         32'h0, 32'h0,        0, 32'h0,        6'h00,  5'd0,  C_CAUSE,   32'h8000_0320);
    add(1, 5'd9,  32'hFFFF_FFFF, 32'h0, 32'h0,        0, 32'h0,        6'h00,  5'd0,  C_COUNT,   32'hFFFF_FFFF);
    add(0, 5'd0,  32'h0,         32'h0, 32'h0,        0, 32'h0,        6'h00,  5'd0,  C_COUNT,   32'hFFFF_FFFF);
    add(0, 5'd0,  32'h0,         32'h0, 32'h0,        0, 32'h0,        6'h00,  5'd0,  C_COUNT,   32'h0);
    add(0, 5'd0,  32'h0,         32'h1, 32'h300,      0, 32'h0,        6'h00,  5'd0,  C_EPC,     32'h300);
    add(0, 5'd0,  32'h0,         32'h0, 32'h0,        0, 32'h0,        6'h00,  5'd0,  C_CAUSE,   32'h0000_0300);
    add(1, 5'd11, 32'h55,        32'hC, 32'h400,      1, 32'h0,        6'h00,  5'd0,  C_COMPARE, 32'h0);
    add(0, 5'd0,  32'h0,         32'h0, 32'h0,        0, 32'h0,        6'h00,  5'd0,  C_CAUSE,   32'h0000_0330);
    add(0, 5'd0,  32'h0,         32'h0, 32'h0,        0, 32'h0,        6'h00,  5'd8,  C_DATA,    32'h8000_0003);
    add(1, 5'd11, 32'd10,        32'h0, 32'h0,        0, 32'h0,        6'h00,  5'd0,  C_COMPARE, 32'd10);

    // Reset: one cycle with rst high
    @(posedge clk); #1;
    rst = 1'b0;
    expect_now(C_STATUS,  32'h0040_0000, -1); check_pop();
    expect_now(C_CAUSE,   32'h0, -1);         check_pop();
    expect_now(C_EPC,     32'h0, -1);         check_pop();
    expect_now(C_COUNT,   32'h0, -1);         check_pop();
    expect_now(C_COMPARE, 32'h0, -1);         check_pop();
    expect_now(C_BADV,    32'h0, -1);         check_pop();
    expect_now(C_TIMER,   32'h0, -1);         check_pop();

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

    // Timer sequence: Compare=10 already, load Count=8
    step(mk(1, 5'd9, 32'd8, C_COUNT, 32'd8), 100);
`ifdef CP0_TIMER_INT_EN
    begin
      int waited;
      waited = 0;
      while (!timer_int_o && waited < 6) begin
        idle_cycle();
        waited++;
      end
      expect_now(C_TIMER, 32'd1, 101); check_pop();
      step(mk(0, 5'd0, 32'd0, C_TIMER, 32'd1), 102);
      step(mk(0, 5'd0, 32'd0, C_CAUSE15, 32'd1), 103);
      step(mk(1, 5'd11, 32'd100, C_TIMER, 32'd0), 104);
    end
`else
    for (int k = 0; k < 8; k++) idle_cycle();
    expect_now(C_TIMER, 32'd0, 101); check_pop();
    step(mk(0, 5'd0, 32'd0, C_CAUSE15, 32'd0), 103);
    step(mk(1, 5'd11, 32'd100, C_COMPARE, 32'd100), 104);
`endif

    if (sb.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL scoreboard: got %0d leftover want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
